// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: receive-only PS/2 keyboard front end.
// Synchronises and de-glitches the PS/2 clock, shifts in 11-bit frames and
// turns the make/break/extended byte stream into an 11-bit key event word
// {toggle, pressed, extended, code}. Bit 10 flips on every event so a
// consumer in another domain can detect new events by edge comparison.
//
// Build option: define PS2_PARITY_CHECK_EN to reject frames whose parity
// is not odd. With the macro undefined the parity bit is consumed and
// ignored, and frame_err reports stop-bit errors only.
module ps2_key_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 24000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        frame_err
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  // ---------------------------------------------------------------------
  // Input synchronisers (reset to the idle-high bus level)
  // ---------------------------------------------------------------------
  logic [1:0] clk_sync;
  logic [1:0] dat_sync;
  logic       clk_s;
  logic       data_s;

  // Two-flop synchronisers on both PS/2 lines
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
    end
  end

  assign clk_s  = clk_sync[1];
  assign data_s = dat_sync[1];

  // ---------------------------------------------------------------------
  // Clock glitch filter: a new level is taken only after FILTER_LEN
  // consecutive samples disagree with the current filtered level.
  // ---------------------------------------------------------------------
  logic          clk_filt;
  logic [FW-1:0] filt_cnt;
  logic          filt_flip;
  logic          fall_edge;

  assign filt_flip = (clk_s != clk_filt) && (filt_cnt == FILT_LAST);
  assign fall_edge = filt_flip && !clk_s;

  // Count disagreeing samples; any agreeing sample restarts the run
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clk_filt <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_s == clk_filt) begin
      filt_cnt <= '0;
    end else if (filt_flip) begin
      clk_filt <= clk_s;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + FW'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Bit-level frame receiver
  // ---------------------------------------------------------------------
  typedef enum logic [1:0] {
    B_IDLE,
    B_DATA,
    B_PARITY,
    B_STOP
  } bit_st_t;

  bit_st_t       bit_st;
  logic [7:0]    shift_q;
  logic [2:0]    bit_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          byte_vld;
  logic [7:0]    byte_q;
  logic          stop_ok;

`ifdef PS2_PARITY_CHECK_EN
  logic par_bit;
  // Good frame: stop bit high and data+parity carry an odd number of ones
  assign stop_ok = data_s && (^{shift_q, par_bit});
`else
  assign stop_ok = data_s;
`endif

  // Frame FSM; a gap of TIMEOUT_CYCLES without a falling edge mid-frame
  // silently drops the partial frame so the next start bit resyncs us
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      bit_st    <= B_IDLE;
      shift_q   <= '0;
      bit_cnt   <= '0;
      tmo_cnt   <= '0;
      byte_vld  <= 1'b0;
      byte_q    <= '0;
      frame_err <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par_bit   <= 1'b0;
`endif
    end else begin
      byte_vld  <= 1'b0;
      frame_err <= 1'b0;
      if (fall_edge) begin
        tmo_cnt <= '0;
        case (bit_st)
          B_IDLE: begin
            // Only a low start bit opens a frame
            if (!data_s) begin
              bit_st  <= B_DATA;
              bit_cnt <= '0;
            end
          end
          B_DATA: begin
            // LSB arrives first, so shift in from the top
            shift_q <= {data_s, shift_q[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) bit_st <= B_PARITY;
          end
          B_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
            par_bit <= data_s;
`endif
            bit_st <= B_STOP;
          end
          B_STOP: begin
            bit_st <= B_IDLE;
            if (stop_ok) begin
              byte_vld <= 1'b1;
              byte_q   <= shift_q;
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: bit_st <= B_IDLE;
        endcase
      end else if (bit_st != B_IDLE) begin
        if (tmo_cnt == TMO_LAST) begin
          bit_st  <= B_IDLE;
          tmo_cnt <= '0;
        end else begin
          tmo_cnt <= tmo_cnt + TW'(1);
        end
      end else begin
        tmo_cnt <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Scan-code event decoder
  // ---------------------------------------------------------------------
  typedef enum logic [1:0] {
    E_BASE,
    E_EXT,
    E_BRK
  } evt_st_t;

  evt_st_t evt_st;
  logic    ext_flag;
  logic    is_drop;

  // Keyboard status/ack bytes and the Pause prefix carry no key event
  assign is_drop = byte_q inside {8'hE1, 8'hAA, 8'hFA, 8'hFE, 8'hEE};

  // Prefix tracking; ext_flag only carries an E0 seen before F0 into BRK
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      evt_st   <= E_BASE;
      ext_flag <= 1'b0;
      ps2_key  <= 11'h000;
    end else if (byte_vld && !is_drop) begin
      if (byte_q == 8'hE0) begin
        // Repeated or late E0 prefixes leave the state alone
        if (evt_st == E_BASE) evt_st <= E_EXT;
      end else if (byte_q == 8'hF0) begin
        if (evt_st != E_BRK) begin
          ext_flag <= (evt_st == E_EXT);
          evt_st   <= E_BRK;
        end
      end else begin
        ps2_key  <= {~ps2_key[10],
                     (evt_st != E_BRK),
                     (evt_st == E_EXT) || ext_flag,
                     byte_q};
        evt_st   <= E_BASE;
        ext_flag <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: directed scenarios followed by
// randomized frames (good, bad stop, bad parity, timed-out partial, reset
// mid-frame) with clock glitches, compared against a prefix-flag model.
module tb_ps2_key_decoder;

  localparam int FILTER_LEN     = 8;
  localparam int TIMEOUT_CYCLES = 600;
  localparam int HALF           = 25;

  logic        clk_sys  = 1'b0;
  logic        reset_n  = 1'b0;
  logic        ps2_clk  = 1'b1;
  logic        ps2_data = 1'b1;
  logic [10:0] ps2_key;
  logic        frame_err;

  ps2_key_decoder #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .ps2_key  (ps2_key),
    .frame_err(frame_err)
  );

  always #5 clk_sys = ~clk_sys;

  int n_chk    = 0;
  int n_pass   = 0;
  int err_seen = 0;
  int err_exp  = 0;
  int wide_err = 0;
  logic fe_q   = 1'b0;

  // Reference state: last event word plus "E0 seen" / "F0 seen" flags
  logic [10:0] m_key = 11'h000;
  bit          m_e0  = 1'b0;
  bit          m_f0  = 1'b0;

  // frame_err pulse counting and width check, sampled mid-cycle
  always @(negedge clk_sys) begin
    if (frame_err) err_seen++;
    if (frame_err && fe_q) wide_err++;
    fe_q = frame_err;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic ref_reset();
    m_key = 11'h000;
    m_e0  = 1'b0;
    m_f0  = 1'b0;
  endtask

  // Apply one accepted byte to the reference model
  task automatic ref_byte(input logic [7:0] b);
    if (b inside {8'hE1, 8'hAA, 8'hFA, 8'hFE, 8'hEE}) return;
    if (b == 8'hE0) begin
      if (!m_f0) m_e0 = 1'b1;
    end else if (b == 8'hF0) begin
      m_f0 = 1'b1;
    end else begin
      m_key = {~m_key[10], ~m_f0, m_e0, b};
      m_e0  = 1'b0;
      m_f0  = 1'b0;
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic par;
    par = ~(^b) ^ bad_par;
    return {~bad_stop, par, b, 1'b0};
  endfunction

  // One clock phase of HALF cycles, optionally with a short opposite-level
  // glitch placed after the filter has settled on this phase's level
  task automatic phase(input logic lvl);
    ps2_clk = lvl;
    wait_cyc(14);
    if ($urandom_range(2) == 0) begin
      ps2_clk = ~lvl;
      wait_cyc(3);
      ps2_clk = lvl;
    end else begin
      wait_cyc(3);
    end
    wait_cyc(HALF - 17);
  endtask

  task automatic send_bits(input logic [10:0] frm, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = frm[i];
      phase(1'b1);
      phase(1'b0);
    end
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
  endtask

  // Full frame; model and expected error count updated from frame content
  task automatic do_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    send_bits(mk_frame(b, bad_par, bad_stop), 11);
    wait_cyc(30);
    if (bad_stop) err_exp++;
`ifdef PS2_PARITY_CHECK_EN
    else if (bad_par) err_exp++;
`endif
    else ref_byte(b);
    chk("key", ps2_key, m_key);
    chk("err_cnt", err_seen, err_exp);
  endtask

  task automatic do_timeout(input logic [7:0] b, input int nbits);
    send_bits(mk_frame(b, 1'b0, 1'b0), nbits);
    wait_cyc(TIMEOUT_CYCLES + 10);
    chk("tmo_key", ps2_key, m_key);
    chk("tmo_err", err_seen, err_exp);
  endtask

  task automatic do_reset_mid(input logic [7:0] b, input int nbits);
    send_bits(mk_frame(b, 1'b0, 1'b0), nbits);
    wait_cyc(5);
    reset_n = 1'b0;
    wait_cyc(3);
    ref_reset();
    chk("rst_mid_key", ps2_key, m_key);
    chk("rst_mid_err", frame_err, 0);
    reset_n = 1'b1;
    wait_cyc(5);
  endtask

  function automatic logic [7:0] pick_byte();
    int s;
    logic [7:0] drops [5];
    drops = '{8'hE1, 8'hAA, 8'hFA, 8'hFE, 8'hEE};
    s = $urandom_range(9);
    if (s < 2) return 8'hE0;
    if (s < 4) return 8'hF0;
    if (s == 4) return drops[$urandom_range(4)];
    return 8'($urandom_range(255));
  endfunction

  initial begin
    // Reset state
    wait_cyc(5);
    chk("rst_key", ps2_key, 11'h000);
    chk("rst_err", frame_err, 0);
    reset_n = 1'b1;
    wait_cyc(5);

    // Plain make code
    do_frame(8'h29, 1'b0, 1'b0);
    chk("make_29", ps2_key, 11'h629);

    // Extended make, then extended break
    do_frame(8'hE0, 1'b0, 1'b0);
    do_frame(8'h75, 1'b0, 1'b0);
    chk("ext_make_75", ps2_key, 11'h375);
    do_frame(8'hE0, 1'b0, 1'b0);
    do_frame(8'hF0, 1'b0, 1'b0);
    do_frame(8'h75, 1'b0, 1'b0);
    chk("ext_brk_75", ps2_key, 11'h575);

    // Even parity on 0x1C
    do_frame(8'h1C, 1'b1, 1'b0);
`ifdef PS2_PARITY_CHECK_EN
    chk("par_1c", ps2_key, 11'h575);
    chk("par_err", err_seen, 1);
`else
    chk("par_1c", ps2_key, 11'h21C);
    chk("par_err", err_seen, 0);
`endif

    // Partial frame abandoned, then a full frame
    do_timeout(8'h16, 5);
    do_frame(8'h16, 1'b0, 1'b0);
`ifdef PS2_PARITY_CHECK_EN
    chk("after_tmo_16", ps2_key, 11'h216);
`else
    chk("after_tmo_16", ps2_key, 11'h616);
`endif

    // Dropped status byte, repeated make
    do_frame(8'hAA, 1'b0, 1'b0);
    do_frame(8'h14, 1'b0, 1'b0);
    do_frame(8'h14, 1'b0, 1'b0);
`ifdef PS2_PARITY_CHECK_EN
    chk("rep_14", ps2_key, 11'h214);
`else
    chk("rep_14", ps2_key, 11'h614);
`endif

    // Bad stop bit
    do_frame(8'h33, 1'b0, 1'b1);

    // Reset after the 4th data bit, then a clean frame
    do_reset_mid(8'h29, 5);
    chk("rst_mid_zero", ps2_key, 11'h000);
    do_frame(8'h29, 1'b0, 1'b0);
    chk("post_rst_29", ps2_key, 11'h629);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      int r;
      logic [7:0] b;
      r = $urandom_range(99);
      b = pick_byte();
      if (r < 8)       do_timeout(b, $urandom_range(10, 1));
      else if (r < 12) do_reset_mid(b, $urandom_range(10, 1));
      else if (r < 22) do_frame(b, 1'b0, 1'b1);
      else if (r < 32) do_frame(b, 1'b1, 1'b0);
      else             do_frame(b, 1'b0, 1'b0);
    end

    chk("fe_width", wide_err, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
